// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register with taken-branch redirect, deferred redirect latch and imem handshake
module pc_redirect_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        br_valid,
    input  logic [1:0]  br_kind,
    input  logic [63:0] br_pc,
    input  logic [63:0] br_offset,
    input  logic [63:0] br_reg_target,
    input  logic        zero_flag,
    input  logic        cond_met,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        imem_req,
    output logic        flush,
    output logic        misalign
);
    typedef enum logic [1:0] {BOOT, FETCH, WAIT} state_t;
    state_t      state;
    logic        pending;
    logic [63:0] pend_target;
    logic [63:0] target;
    logic        advance;
    logic        taken;
    logic        capture;
    always_comb begin
        advance = state != BOOT && imem_ready && !stall;
        taken   = br_valid && (br_kind == 2'b00 || br_kind == 2'b11 ||
                  (br_kind == 2'b01 && zero_flag) || (br_kind == 2'b10 && cond_met));
        capture = taken && !pending;
        target  = br_kind == 2'b11 ? {br_reg_target[63:2], 2'b00} : br_pc + {br_offset[61:0], 2'b00};
    end
    assign pc_plus4 = pc + 64'd4;
    assign imem_req = state != BOOT;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            pending     <= 1'b0;
            pend_target <= 64'h0;
            flush       <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state    <= (state == BOOT || imem_ready) ? FETCH : WAIT;
            flush    <= advance && (pending || capture);
            misalign <= capture && br_kind == 2'b11 && |br_reg_target[1:0];
            if (advance) begin
                pc      <= pending ? pend_target : capture ? target : pc_plus4;
                pending <= 1'b0;
            end else if (capture) begin
                pending     <= 1'b1;
                pend_target <= target;
            end
        end
    end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: scoreboard bench with a behavioural PC model, directed scenarios and random traffic
module tb_pc_redirect_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic [1:0]  br_kind = 2'b00;
    logic [63:0] br_pc = 64'h0;
    logic [63:0] br_offset = 64'h0;
    logic [63:0] br_reg_target = 64'h0;
    logic        zero_flag = 1'b0;
    logic        cond_met = 1'b0;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        imem_req;
    logic        flush;
    logic        misalign;

    pc_redirect_unit #(.RESET_PC(64'h0)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .imem_ready(imem_ready),
        .br_valid(br_valid), .br_kind(br_kind), .br_pc(br_pc), .br_offset(br_offset),
        .br_reg_target(br_reg_target), .zero_flag(zero_flag), .cond_met(cond_met),
        .pc(pc), .pc_plus4(pc_plus4), .imem_req(imem_req), .flush(flush), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic        req;
        logic        fl;
        logic        mis;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int passed = 0;
    int total = 0;

    // model state: whether fetch has started, the PC, and a deferred redirect
    logic        m_live = 1'b0;
    logic [63:0] m_pc = 64'h0;
    logic        m_pend = 1'b0;
    logic [63:0] m_tgt = 64'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 64'd4);
            chk("imem_req", {63'h0, imem_req}, {63'h0, e.req});
            chk("flush", {63'h0, flush}, {63'h0, e.fl});
            chk("misalign", {63'h0, misalign}, {63'h0, e.mis});
        end
    end

    task automatic step(input logic rn, input logic st, input logic rdy, input logic bv,
                        input logic [1:0] k, input logic [63:0] bpc, input logic [63:0] off,
                        input logic [63:0] rt, input logic z, input logic c);
        exp_t x;
        logic adv, tk;
        logic [63:0] t;
        @(negedge clk);
        reset_n = rn; stall = st; imem_ready = rdy; br_valid = bv; br_kind = k;
        br_pc = bpc; br_offset = off; br_reg_target = rt; zero_flag = z; cond_met = c;
        x.fl = 1'b0;
        x.mis = 1'b0;
        if (!rn) begin
            m_live = 1'b0; m_pc = 64'h0; m_pend = 1'b0;
        end else begin
            adv = m_live && rdy && !st;
            tk = bv && !m_pend && (k == 0 || k == 3 || (k == 1 && z) || (k == 2 && c));
            t = (k == 3) ? rt - (rt % 4) : bpc + off * 64'd4;
            x.mis = tk && k == 3 && (rt % 4) != 0;
            if (adv) begin
                if (m_pend) begin m_pc = m_tgt; m_pend = 1'b0; x.fl = 1'b1; end
                else if (tk) begin m_pc = t; x.fl = 1'b1; end
                else m_pc = m_pc + 64'd4;
            end else if (tk) begin
                m_pend = 1'b1; m_tgt = t;
            end
            m_live = 1'b1;
        end
        x.pc = m_pc;
        x.req = m_live;
        q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic st, input logic rdy);
        step(1'b1, st, rdy, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        chk("reset_req", {63'h0, imem_req}, 64'h0);
        idle(1'b0, 1'b1);
        chk("boot_req", {63'h0, imem_req}, 64'h1);
        repeat (3) idle(1'b0, 1'b1);
        chk("seq_pc12", pc, 64'd12);
        // B backwards to 0
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'h8, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0, 1'b0);
        chk("b_pc", pc, 64'h0);
        chk("b_flush", {63'h0, flush}, 64'h1);
        idle(1'b0, 1'b1);
        chk("b_flush_end", {63'h0, flush}, 64'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 64'h4, 64'h40, 64'h0, 1'b0, 1'b0);
        chk("cbz_nt_pc", pc, 64'h8);
        // B.cond under stall, with a wrong-path B during the stall
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 64'h100, 64'h3, 64'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 64'h0, 64'h100, 64'h0, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        chk("stall_hold", pc, 64'h8);
        idle(1'b0, 1'b1);
        chk("pend_pc", pc, 64'h10C);
        idle(1'b0, 1'b1);
        chk("pend_after", pc, 64'h110);
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 64'h0, 64'h0, 64'h1003, 1'b0, 1'b0);
        chk("br_pc", pc, 64'h1000);
        chk("br_mis", {63'h0, misalign}, 64'h1);
        repeat (4) idle(1'b0, 1'b0);
        chk("wait_hold", pc, 64'h1000);
        idle(1'b0, 1'b1);
        chk("wait_adv", pc, 64'h1004);
        idle(1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 64'h0, 64'h40, 64'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
        chk("wait_reset_pc", pc, 64'h0);
        repeat (2) idle(1'b0, 1'b1);
        chk("no_stale_flush", {63'h0, flush}, 64'h0);
        // wrap-around of both sequential and branch targets
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        idle(1'b0, 1'b1);
        chk("wrap_pc", pc, 64'h0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'hFFFF_FFFF_FFFF_FFF8, 64'h4, 64'h0, 1'b0, 1'b0);
        chk("wrap_b", pc, 64'h8);
        for (int i = 0; i < 400; i++) begin
            logic [63:0] off;
            off = ($urandom_range(0, 1) == 0) ? {{32{1'b0}}, $urandom} : {$urandom, $urandom};
            step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) < 2, 2'($urandom_range(0, 3)), {$urandom, $urandom},
                 off, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
